// File: rtl/yiq_to_rgb_if.sv
// ---------------------------------------------------------------------------
// yiq_to_rgb_if
// Streaming pixel bus for the YIQ -> RGB converter: one valid/ready input
// channel carrying Y/I/Q plus per-pixel mono flag and sideband, and one
// valid/ready output channel carrying clamped R/G/B plus the same sideband.
//
//   in_valid/in_ready   input handshake
//   y, i, q             luma (unsigned), chroma (offset binary, 128 = zero)
//   mono                force R=G=B=Y for this pixel
//   in_sb               sideband (sync/DE), qualified by in_valid
//   out_valid/out_ready output handshake
//   r, g, b             clamped 8-bit colour
//   out_sb              sideband aligned to r/g/b
//
// master: pixel source + pixel sink side.  slave: the converter.
// ---------------------------------------------------------------------------
interface yiq_to_rgb_if #(
  parameter int SB_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      y;
  logic [7:0]      i;
  logic [7:0]      q;
  logic            mono;
  logic [SB_W-1:0] in_sb;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      r;
  logic [7:0]      g;
  logic [7:0]      b;
  logic [SB_W-1:0] out_sb;

  modport master (
    output in_valid, y, i, q, mono, in_sb, out_ready,
    input  in_ready, out_valid, r, g, b, out_sb
  );

  modport slave (
    input  in_valid, y, i, q, mono, in_sb, out_ready,
    output in_ready, out_valid, r, g, b, out_sb
  );
endinterface

// File: rtl/yiq_to_rgb.sv
// ---------------------------------------------------------------------------
// yiq_to_rgb
// NTSC YIQ to RGB converter, 8.8 fixed point, three register stages with a
// single global advance (valid/ready backpressure, bubbles preserved).
//
//   clk   system clock
//   rst   asynchronous active-high reset; clears all stage valids and the
//         output pixel, holds in_ready low
//   bus   yiq_to_rgb_if.slave (input pixel stream, output pixel stream)
//
// Parameters:
//   SB_W   sideband width carried alongside every pixel
//   ROUND  1 = round to nearest (add 128 before >>8), 0 = floor
// ---------------------------------------------------------------------------
module yiq_to_rgb #(
  parameter int SB_W  = 3,
  parameter int ROUND = 1
) (
  input  logic         clk,
  input  logic         rst,
  yiq_to_rgb_if.slave  bus
);

  // Matrix coefficients x256, rounded (0.956, 0.621, 0.272, 0.647, 1.106, 1.703)
  localparam logic signed [19:0] C_R_I =  20'sd245;
  localparam logic signed [19:0] C_R_Q =  20'sd159;
  localparam logic signed [19:0] C_G_I = -20'sd70;
  localparam logic signed [19:0] C_G_Q = -20'sd166;
  localparam logic signed [19:0] C_B_I = -20'sd283;
  localparam logic signed [19:0] C_B_Q =  20'sd436;

  // Drop the 8 fraction bits (optionally rounding) and clamp to 0..255.
  function automatic logic [7:0] round_sat(input logic signed [19:0] acc);
    logic signed [19:0] t;
    t = (acc + ((ROUND != 0) ? 20'sd128 : 20'sd0)) >>> 8;
    if (t < 0)
      return 8'd0;
    else if (t > 20'sd255)
      return 8'd255;
    else
      return t[7:0];
  endfunction

  logic                   r_vld_p0, r_vld_p1, r_vld_p2;
  logic [7:0]             r_y_p0;
  logic signed [8:0]      r_is_p0, r_qs_p0;
  logic                   r_mono_p0;
  logic [SB_W-1:0]        r_sb_p0;
  logic signed [19:0]     r_acc_r_p1, r_acc_g_p1, r_acc_b_p1;
  logic [7:0]             r_y_p1;
  logic                   r_mono_p1;
  logic [SB_W-1:0]        r_sb_p1;
  logic [7:0]             r_r_p2, r_g_p2, r_b_p2;
  logic [SB_W-1:0]        r_sb_p2;

  logic                   w_adv;
  logic signed [19:0]     w_y_ext, w_is_ext, w_qs_ext;
  logic signed [19:0]     w_acc_r, w_acc_g, w_acc_b;

  // Whole pipeline moves together; it only stalls when the output is full
  // and the sink refuses it.
  assign w_adv        = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready = w_adv && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p0 <= bus.in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- stage 0: capture Y, re-centre I/Q to signed, carry mono/sideband ----
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_y_p0    <= bus.y;
      r_is_p0   <= $signed({1'b0, bus.i}) - 9'sd128;
      r_qs_p0   <= $signed({1'b0, bus.q}) - 9'sd128;
      r_mono_p0 <= bus.mono;
      r_sb_p0   <= bus.in_sb;
    end
  end

  // ---- stage 1: 8.8 accumulators (|acc| < 2^18, 20 bits never overflow) ----
  assign w_y_ext  = {4'b0000, r_y_p0, 8'h00};
  assign w_is_ext = {{11{r_is_p0[8]}}, r_is_p0};
  assign w_qs_ext = {{11{r_qs_p0[8]}}, r_qs_p0};
  assign w_acc_r  = w_y_ext + C_R_I * w_is_ext + C_R_Q * w_qs_ext;
  assign w_acc_g  = w_y_ext + C_G_I * w_is_ext + C_G_Q * w_qs_ext;
  assign w_acc_b  = w_y_ext + C_B_I * w_is_ext + C_B_Q * w_qs_ext;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_acc_r_p1 <= w_acc_r;
      r_acc_g_p1 <= w_acc_g;
      r_acc_b_p1 <= w_acc_b;
      r_y_p1     <= r_y_p0;
      r_mono_p1  <= r_mono_p0;
      r_sb_p1    <= r_sb_p0;
    end
  end

  // ---- stage 2: round/clamp or mono bypass; output register ----
  // Loaded only with valid pixels so the outputs stay at their reset value
  // (or last pixel) across bubbles and never expose stale in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_p2  <= 8'd0;
      r_g_p2  <= 8'd0;
      r_b_p2  <= 8'd0;
      r_sb_p2 <= '0;
    end else if (w_adv && r_vld_p1) begin
      if (r_mono_p1) begin
        r_r_p2 <= r_y_p1;
        r_g_p2 <= r_y_p1;
        r_b_p2 <= r_y_p1;
      end else begin
        r_r_p2 <= round_sat(r_acc_r_p1);
        r_g_p2 <= round_sat(r_acc_g_p1);
        r_b_p2 <= round_sat(r_acc_b_p1);
      end
      r_sb_p2 <= r_sb_p1;
    end
  end

  assign bus.out_valid = r_vld_p2;
  assign bus.r         = r_r_p2;
  assign bus.g         = r_g_p2;
  assign bus.b         = r_b_p2;
  assign bus.out_sb    = r_sb_p2;

endmodule

// File: tb/tb_yiq_to_rgb.sv
// ---------------------------------------------------------------------------
// tb_yiq_to_rgb
// Scoreboard bench for yiq_to_rgb (SB_W=3, ROUND=1). Expected pixels are
// computed from the YIQ matrix when an input transfer is seen and compared
// in order when the converter emits a pixel.
// ---------------------------------------------------------------------------
module tb_yiq_to_rgb;

  logic clk;
  logic rst;

  yiq_to_rgb_if #(.SB_W(3)) bus ();

  yiq_to_rgb #(.SB_W(3), .ROUND(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] sb;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   lat_chk  = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input int acc);
    int t;
    t = (acc + 128) >>> 8;
    if (t < 0) return 8'd0;
    if (t > 255) return 8'd255;
    return 8'(t);
  endfunction

  function automatic exp_t model(input logic [7:0] y, input logic [7:0] i, input logic [7:0] q,
                                 input logic m, input logic [2:0] sb);
    exp_t e;
    int ys, is, qs;
    ys = int'(y);
    is = int'(i) - 128;
    qs = int'(q) - 128;
    if (m) begin
      e.r = y; e.g = y; e.b = y;
    end else begin
      e.r = sat8(ys * 256 + 245 * is + 159 * qs);
      e.g = sat8(ys * 256 - 70 * is - 166 * qs);
      e.b = sat8(ys * 256 - 283 * is + 436 * qs);
    end
    e.sb  = sb;
    e.cyc = cyc;
    e.lat = lat_chk;
    return e;
  endfunction

  // Sink readiness: always 1 unless the random-stall phase is active.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reset discards everything in flight.
  initial forever begin
    @(posedge rst);
    sb_q.delete();
  end

  // Monitor on the falling edge: handshakes seen here complete on the next rise.
  initial begin
    exp_t e;
    bit prev_stall;
    logic [7:0] hr, hg, hb;
    logic [2:0] hsb;
    prev_stall = 1'b0;
    hr = '0; hg = '0; hb = '0; hsb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check_eq("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
        if (prev_stall) begin
          check_eq("hold_valid", 32'(bus.out_valid), 1);
          check_eq("hold_rgb", {8'd0, bus.r, bus.g, bus.b}, {8'd0, hr, hg, hb});
          check_eq("hold_sb", 32'(bus.out_sb), 32'(hsb));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        hr = bus.r; hg = bus.g; hb = bus.b; hsb = bus.out_sb;
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_out", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("r", 32'(bus.r), 32'(e.r));
            check_eq("g", 32'(bus.g), 32'(e.g));
            check_eq("b", 32'(bus.b), 32'(e.b));
            check_eq("sb", 32'(bus.out_sb), 32'(e.sb));
            if (e.lat) check_eq("latency", 32'(cyc - e.cyc), 3);
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb_q.push_back(model(bus.y, bus.i, bus.q, bus.mono, bus.in_sb));
      end
    end
  end

  // Present one pixel and hold it until accepted; returns at rise+1 after transfer.
  task automatic send(input logic [7:0] y, input logic [7:0] i, input logic [7:0] q,
                      input logic m, input logic [2:0] sb);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.y = y; bus.i = i; bus.q = q; bus.mono = m; bus.in_sb = sb;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.y = '0; bus.i = '0; bus.q = '0; bus.mono = 1'b0; bus.in_sb = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 0);
    check_eq("rst_out_sb", 32'(bus.out_sb), 0);
    rst = 1'b0;
    idle(2);
    check_eq("post_rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("post_rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 0);

    // Directed pixels: grey, clamp high, clamp low, mono with sideband.
    lat_chk = 1'b1;
    send(8'd128, 8'd128, 8'd128, 1'b0, 3'b010);
    send(8'd255, 8'd255, 8'd128, 1'b0, 3'b001);
    send(8'd0,   8'd0,   8'd128, 1'b0, 3'b110);
    send(8'd200, 8'd0,   8'd255, 1'b1, 3'b101);
    idle(6);

    // Bubble pattern 1,0,1,1,0: each pixel must still arrive exactly 3 later.
    send(8'd10, 8'd200, 8'd50, 1'b0, 3'b011);
    idle(1);
    send(8'd90, 8'd30, 8'd220, 1'b0, 3'b100);
    send(8'd170, 8'd128, 8'd0, 1'b0, 3'b111);
    idle(1);
    idle(5);

    // Random backpressure stream.
    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0), 3'(k));
    end
    rand_rdy = 1'b0;
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("stream_drain", 32'(sb_q.size()), 0);
    idle(2);

    // Mid-cycle reset with three pixels in flight.
    lat_chk = 1'b1;
    send(8'd50, 8'd60, 8'd70, 1'b0, 3'b001);
    send(8'd51, 8'd61, 8'd71, 1'b0, 3'b010);
    send(8'd52, 8'd62, 8'd72, 1'b0, 3'b011);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("async_rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    idle(6);
    send(8'd30, 8'd180, 8'd90, 1'b0, 3'b110);
    idle(6);

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("final_drain", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/yiq_to_rgb.md
Name: yiq_to_rgb

Overview:
- Streaming NTSC YIQ to RGB converter, 8.8 fixed point, 3-stage pipeline with valid/ready backpressure.
- Sits on the decode side of the CRT chain, after chroma demodulation and before the RGB pixel sink.
- Accepts offset-binary I/Q (128 = zero), the same 8-bit encoding the RGB-to-YIQ encoder produces.
- Carries a sideband field (sync/DE) through the pipeline aligned with each pixel.

Parameters:
SB_W, 3, width of sideband passed through unchanged (e.g. {de,vsync,hsync})
ROUND, 1, 1 = add 128 before the >>8; 0 = plain truncation (floor)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept input this cycle
y  in  8  luma, unsigned 0..255
i  in  8  in-phase chroma, offset binary (signed value = i-128)
q  in  8  quadrature chroma, offset binary (signed value = q-128)
mono  in  1  per-pixel: force R=G=B=Y, ignore I/Q
in_sb  in  SB_W  sideband, qualified by in_valid
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
r  out  8  red, clamped 0..255
g  out  8  green, clamped 0..255
b  out  8  blue, clamped 0..255
out_sb  out  SB_W  sideband aligned to r/g/b

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. While rst=1: all stage-valid flags=0, out_valid=0, r/g/b=0, out_sb=0. in_ready is held 0 during reset.
- Reset asserted mid-stream discards every in-flight pixel. There is no partial output after reset release.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (and !rst).
  - An input transfer occurs on in_valid && in_ready.
  - An output transfer occurs on out_valid && out_ready.
- When adv=0, every stage holds its data and valid. r/g/b/out_sb must be stable while out_valid=1 && out_ready=0.
- When adv=1, every stage shifts. A stage whose upstream is invalid receives valid=0; bubbles are preserved, not collapsed.
- Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 pixel/clk.
- S1: register y, is=i-128, qs=q-128 (signed 9-bit), mono, and sb.
- S2: compute signed 20-bit accumulators. Y contributes Y*256 to each.
  - accR = Y*256 + 245*is + 159*qs
  - accG = Y*256 - 70*is - 166*qs
  - accB = Y*256 - 283*is + 436*qs
  - Coefficients are 0.956, 0.621, 0.272, 0.647, 1.106 and 1.703, each ×256 rounded.
- S3: add 128 if ROUND=1, then arithmetic >>8.
  - Result < 0 clamps to 0; result > 255 clamps to 255; otherwise take the low 8 bits.
  - If mono=1, r=g=b=Y regardless of the accumulators.
- Boundary: Y=0..255 with is,qs at −128..127 never overflows 20 bits (max |acc| < 2^18).
- Simultaneous input and output transfer in the same cycle with the pipeline full is legal and sustains full rate.
- in_valid without in_ready: the input is not consumed, and the source must hold it.

Test Plan:
- Reset, then y=128,i=128,q=128,in_valid=1 (ROUND=1), out_ready=1 -> out_valid rises exactly 3 clocks later with r=g=b=128; after reset release all outputs are 0.
- y=255,i=255,q=128 -> r=255 (377 clamped), g=220, b=115. Then y=0,i=0,q=128 -> r=0 (negative clamped), g=35, b=142.
- Same as the first scenario with mono=1, y=200,i=0,q=255 -> r=g=b=200; in_sb=3'b101 appears on out_sb with that pixel.
- Continuous stream of 16 pixels, out_ready toggled 1/0 pseudo-randomly -> no pixel lost or duplicated; order and sideband preserved; outputs stable during stall; in_ready==(!out_valid||out_ready).
- in_valid pattern 1,0,1,1,0 with out_ready=1 -> out_valid pattern identical, delayed 3 cycles.
- Assert rst for 1 cycle asynchronously (mid-cycle) with 3 pixels in flight -> out_valid drops immediately, no stale pixel emerges after release; the first new pixel emerges 3 cycles after its input transfer.
